serial_subtractor: RTL and testbench
====================================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter WIDTH, default 4, SHALL set the operand and difference width in bits (legal range 2..32).
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-004 start  input  1  SHALL request a subtraction; sampled only in IDLE or DONE.
REQ-005 a  input  WIDTH  SHALL be the minuend, captured on an accepted start.
REQ-006 b  input  WIDTH  SHALL be the subtrahend, captured on an accepted start.
REQ-007 bin  input  1  SHALL be the borrow-in, captured on an accepted start.
REQ-008 busy  output  1  SHALL be high while bits are being processed.
REQ-009 done  output  1  SHALL be a one-cycle pulse marking a valid result.
REQ-010 d  output  WIDTH  SHALL carry the difference a - b - bin, modulo 2^WIDTH.
REQ-011 bout  output  1  SHALL carry the final borrow-out: 1 when a < b + bin, unsigned.
REQ-012 ovf  output  1  SHALL flag two's-complement overflow.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-014 Start accepted at edge k (state IDLE or DONE) SHALL capture a, b and bin into internal shift registers and the borrow flop, clear bit counter cnt, and enter SHIFT.
REQ-015 In SHIFT, each edge SHALL compute one bit, LSB first: diff = a_i ^ b_i ^ br, br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br); the operands shift right and cnt increments.
REQ-016 Edges k+1..k+WIDTH SHALL process bits 0..WIDTH-1; the edge that processes bit WIDTH-1 SHALL load d, bout and ovf, assert done and enter DONE.
REQ-017 done SHALL be high for exactly the one cycle following edge k+WIDTH; with no new start, the next edge SHALL return the FSM to IDLE.
REQ-018 busy SHALL equal (state == SHIFT); busy and done SHALL never be high together.
REQ-019 start while in SHIFT SHALL be ignored, with no effect on operands or timing.
REQ-020 start while in DONE SHALL be accepted per REQ-014, giving back-to-back operation with a throughput of one result per WIDTH+1 cycles.
REQ-021 ovf SHALL equal (borrow into bit WIDTH-1) XOR bout.
REQ-022 d, bout and ovf SHALL change only at the completion edge (REQ-016) or on reset, and SHALL otherwise hold their last result.
REQ-023 a, b and bin SHALL be don't-care except in the cycle a start is accepted.

Reset
REQ-024 Asserting rst_n low at any time, including mid-SHIFT, SHALL immediately force IDLE, cnt=0, borrow flop=0, busy=0, done=0, d=0, bout=0 and ovf=0. Any in-flight operation SHALL be discarded and SHALL produce no done pulse.
REQ-025 After rst_n deasserts, the first start SHALL be accepted no earlier than the first rising clk edge at which rst_n is high.

Structure
REQ-026 A shared package serial_sub_pkg SHALL hold the state encodings (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) and the default WIDTH constant.
REQ-027 The per-bit logic SHALL be a combinational sub-module full_subtractor (ports: x, y, bin, diff, bout), instantiated once.
REQ-028 cnt SHALL be $clog2(WIDTH)+1 bits wide; no other arithmetic operator SHALL be used in the datapath.

Verification (WIDTH=4)
REQ-029 Start with a=5, b=3, bin=0 -> done pulses 5 cycles after the start edge; d=2, bout=0, ovf=0; busy high for 4 cycles.
REQ-030 a=3, b=5, bin=0 -> d=14, bout=1, ovf=0; a=8, b=1, bin=0 -> d=7, bout=0, ovf=1.
REQ-031 a=0, b=0, bin=1 -> d=15, bout=1, ovf=0.
REQ-032 Start pulsed during SHIFT with different operands -> ignored; the first result is unchanged and there is exactly one done pulse.
REQ-033 rst_n pulsed low during the second SHIFT cycle -> all outputs are 0 immediately, no done pulse follows, and a fresh start afterwards completes correctly.
REQ-034 Start held high continuously with operands changed every DONE cycle -> done pulses every 5 cycles and each d matches its own operands.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding,
// default operand width and the bit-counter width helper.
package serial_sub_pkg;

   localparam int DEFAULT_WIDTH = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Bit counter must hold values up to WIDTH-1 with one spare bit.
   function automatic int cnt_width(input int width);
      return $clog2(width) + 1;
   endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Request/result bundle of the serial subtractor.
// Handshake: start is a request that the subtractor accepts only while it
// is idle or presenting a result (IDLE or DONE); a, b and bin are sampled
// on the accepting edge and are don't-care otherwise. done is a one-cycle
// pulse during which d, bout and ovf carry the new result; they hold that
// result until the next completion or reset. busy is high while bits are
// being shifted, and busy and done are never high together.
interface serial_subtractor_if
   import serial_sub_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
);

   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] d;
   logic             bout;
   logic             ovf;

   modport master (
      output start, a, b, bin,
      input  busy, done, d, bout, ovf
   );

   modport slave (
      input  start, a, b, bin,
      output busy, done, d, bout, ovf
   );

endinterface

// File: rtl/full_subtractor.sv
// One-bit full subtractor: computes x - y - bin.
module full_subtractor (
   input  logic x,
   input  logic y,
   input  logic bin,
   output logic diff,
   output logic bout
);

   // Difference bit and borrow generated by this bit position.
   always_comb begin
      diff = x ^ y ^ bin;
      bout = (~x & y) | (~(x ^ y) & bin);
   end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - bin one bit per clock, LSB first,
// then presents the difference, final borrow and signed overflow.
module serial_subtractor
   import serial_sub_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic                clk,
   input  logic                rst_n,
   serial_subtractor_if.slave  bus,
   output state_t              state
);

   localparam int CW = cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   state_t           state_q;
   state_t           state_d;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] diff_sr;
   logic             br;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] d_q;
   logic             bout_q;
   logic             ovf_q;
   logic             accept;
   logic             last;
   logic             fs_diff;
   logic             fs_bout;

   // A start only counts while idle or while a result is being presented.
   assign accept = bus.start && ((state_q == IDLE) || (state_q == DONE));
   assign last   = (state_q == SHIFT) && (cnt == LAST_BIT);

   full_subtractor u_fs (
      .x    (a_sr[0]),
      .y    (b_sr[0]),
      .bin  (br),
      .diff (fs_diff),
      .bout (fs_bout)
   );

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic: SHIFT for WIDTH bits, one DONE cycle, then idle or restart.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.start) state_d = SHIFT;
         SHIFT:   if (last) state_d = DONE;
         DONE:    state_d = bus.start ? SHIFT : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Operand shifting, borrow chain, bit counter and result capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sr    <= '0;
         b_sr    <= '0;
         diff_sr <= '0;
         br      <= 1'b0;
         cnt     <= '0;
         d_q     <= '0;
         bout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else if (accept) begin
         a_sr <= bus.a;
         b_sr <= bus.b;
         br   <= bus.bin;
         cnt  <= '0;
      end else if (state_q == SHIFT) begin
         a_sr    <= a_sr >> 1;
         b_sr    <= b_sr >> 1;
         br      <= fs_bout;
         cnt     <= cnt + CNT_ONE;
         diff_sr <= {fs_diff, diff_sr[WIDTH-1:1]};
         if (last) begin
            d_q    <= {fs_diff, diff_sr[WIDTH-1:1]};
            bout_q <= fs_bout;
            // br is the borrow into the MSB at this point.
            ovf_q  <= br ^ fs_bout;
         end
      end
   end

   assign bus.busy = (state_q == SHIFT);
   assign bus.done = (state_q == DONE);
   assign bus.d    = d_q;
   assign bus.bout = bout_q;
   assign bus.ovf  = ovf_q;
   assign state    = state_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor (WIDTH=4): directed and random subtractions,
// start during SHIFT, reset mid-operation and back-to-back operation.
module tb_serial_subtractor;
   import serial_sub_pkg::*;

   localparam int W = 4;

   logic   clk = 1'b0;
   logic   rst_n = 1'b0;
   state_t state;

   serial_subtractor_if #(.WIDTH(W)) bus ();

   serial_subtractor #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus),
      .state (state)
   );

   // Clock.
   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   logic [W+1:0] exp_q[$];
   logic [W+1:0] last_res = '0;
   logic [W+1:0] mon_exp;

   // Reference: a - b - bin in plain integers, result packed {ovf, bout, d}.
   function automatic logic [W+1:0] model(input int a, input int b, input int bin);
      int diff;
      int sa;
      int sb;
      int sdiff;
      logic [W-1:0] dv;
      logic bo;
      logic ov;
      diff = a - b - bin;
      dv = W'(diff & ((1 << W) - 1));
      bo = (diff < 0);
      sa = (a >= (1 << (W - 1))) ? a - (1 << W) : a;
      sb = (b >= (1 << (W - 1))) ? b - (1 << W) : b;
      sdiff = sa - sb - bin;
      ov = (sdiff > (1 << (W - 1)) - 1) || (sdiff < -(1 << (W - 1)));
      return {ov, bo, dv};
   endfunction

   task automatic check(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
      end
   endtask

   // Monitor: pops the expected result on every done pulse; outputs hold otherwise.
   always @(negedge clk) begin
      if (rst_n) begin
         check("busy_done_excl", int'(bus.busy & bus.done), 0);
         check("busy_vs_state", int'(bus.busy), int'(state == SHIFT));
         if (bus.done) begin
            if (exp_q.size() == 0) begin
               check("unexpected_done", 1, 0);
            end else begin
               mon_exp = exp_q.pop_front();
               check("d", int'(bus.d), int'(mon_exp[W-1:0]));
               check("bout", int'(bus.bout), int'(mon_exp[W]));
               check("ovf", int'(bus.ovf), int'(mon_exp[W+1]));
               last_res = mon_exp;
            end
         end else begin
            check("hold", int'({bus.ovf, bus.bout, bus.d}), int'(last_res));
         end
      end
   end

   // Drive a start with operands and queue the expected result.
   task automatic issue(input int a, input int b, input int bin);
      bus.start = 1'b1;
      bus.a     = W'(a);
      bus.b     = W'(b);
      bus.bin   = 1'(bin);
      exp_q.push_back(model(a, b, bin));
   endtask

   // One operation from idle; optionally pulse start with other operands mid-SHIFT.
   task automatic run_op(input int a, input int b, input int bin, input bit glitch);
      int n;
      int busy_cnt;
      int dones;
      @(posedge clk);
      #1 issue(a, b, bin);
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.a     = W'($urandom);
      bus.b     = W'($urandom);
      bus.bin   = 1'($urandom);
      n = 0;
      busy_cnt = 0;
      dones = 0;
      while (dones == 0 && n < 20) begin
         @(negedge clk);
         n++;
         if (glitch && n == 2) begin
            bus.start = 1'b1;
            bus.a     = W'(~a);
            bus.b     = W'(a);
            bus.bin   = 1'(~bin);
         end else if (glitch && n == 3) begin
            bus.start = 1'b0;
         end
         if (bus.busy) busy_cnt++;
         if (bus.done) dones++;
      end
      check("done_seen", dones, 1);
      check("latency", n, W + 1);
      check("busy_cycles", busy_cnt, W);
   endtask

   task automatic check_dir(input int dv, input int bo, input int ov);
      check("dir_d", int'(bus.d), dv);
      check("dir_bout", int'(bus.bout), bo);
      check("dir_ovf", int'(bus.ovf), ov);
   endtask

   task automatic check_reset_outputs();
      check("rst_busy", int'(bus.busy), 0);
      check("rst_done", int'(bus.done), 0);
      check("rst_d", int'(bus.d), 0);
      check("rst_bout", int'(bus.bout), 0);
      check("rst_ovf", int'(bus.ovf), 0);
      check("rst_state", int'(state), int'(IDLE));
   endtask

   // Reset asserted in the second SHIFT cycle: discard the operation.
   task automatic reset_mid_shift();
      int dones;
      @(posedge clk);
      #1 issue(9, 4, 0);
      @(posedge clk);
      #1 bus.start = 1'b0;
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check_reset_outputs();
      exp_q.delete();
      last_res = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      #2 rst_n = 1'b1;
      dones = 0;
      repeat (8) begin
         @(negedge clk);
         if (bus.done) dones++;
      end
      check("no_done_after_rst", dones, 0);
   endtask

   // Start held high, new operands presented in every DONE cycle.
   task automatic back_to_back(input int total);
      int got;
      int gap;
      int cyc;
      @(posedge clk);
      #1 issue($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 1));
      got = 0;
      gap = 0;
      cyc = 0;
      while (got < total && cyc < 200) begin
         @(negedge clk);
         cyc++;
         gap++;
         if (bus.done) begin
            got++;
            if (got > 1) check("b2b_interval", gap, W + 1);
            gap = 0;
            if (got < total) issue($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 1));
            else bus.start = 1'b0;
         end
      end
      bus.start = 1'b0;
      check("b2b_count", got, total);
   endtask

   // Main sequence.
   initial begin
      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      bus.bin   = 1'b0;
      repeat (2) @(posedge clk);
      #1 check_reset_outputs();
      @(negedge clk);
      #2 rst_n = 1'b1;

      run_op(5, 3, 0, 1'b0);
      check_dir(2, 0, 0);
      run_op(3, 5, 0, 1'b0);
      check_dir(14, 1, 0);
      run_op(8, 1, 0, 1'b0);
      check_dir(7, 0, 1);
      run_op(0, 0, 1, 1'b0);
      check_dir(15, 1, 0);
      run_op(6, 2, 1, 1'b1);
      check_dir(3, 0, 0);

      reset_mid_shift();
      run_op(12, 5, 1, 1'b0);
      check_dir(6, 0, 1);

      for (int i = 0; i < 25; i++) begin
         run_op($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 1),
                1'($urandom_range(0, 1)));
      end

      back_to_back(8);

      repeat (4) @(negedge clk);
      check("queue_empty", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
